// File: rtl/instr_prefetch_pkg.sv
// Shared constants and types for the instruction prefetch stage and its consumers.
package instr_prefetch_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int BYTE_W      = 8;
    localparam int INSTR_W     = INSTR_BYTES * BYTE_W;
    localparam int AW_DEFAULT  = 8;

    typedef struct packed {
        logic [INSTR_W-1:0]    instr;
        logic [AW_DEFAULT-1:0] pc;
    } fetch_entry_t;

    // Control-flow opcodes shared with the datapath (bits [31:26]); jr is R-type + funct.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BGEZ  = 6'h01;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNEQ  = 6'h05;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] ins);
        return ins[INSTR_W-1:INSTR_W-6];
    endfunction

endpackage

// File: rtl/instr_prefetch_if.sv
// Memory-read, redirect and instruction-delivery signals of the prefetch stage.
interface instr_prefetch_if
    import instr_prefetch_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              mem_rd;
    logic [AW-1:0]     mem_addr;
    logic [BYTE_W-1:0] mem_rdata;
    logic              redirect_valid;
    logic [AW-1:0]     redirect_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [AW-1:0]     instr_pc;
    logic [CW-1:0]     fifo_count;

    modport master (
        output mem_rd, mem_addr, instr_valid, instr, instr_pc, fifo_count,
        input  mem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  mem_rd, mem_addr, instr_valid, instr, instr_pc, fifo_count,
        output mem_rdata, redirect_valid, redirect_pc, instr_ready
    );

endinterface

// File: rtl/instr_fifo.sv
// Prefetch FIFO with synchronous clear and a registered head so the consumer
// never sees a combinational path from its ready to the delivered word.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [DW-1:0]            push_data_i,
    input  logic                     pop_i,
    output logic [DW-1:0]            head_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] head_q, head_d;
    logic          wr_en;

    assign wr_en = push_i && !clear_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
        // Next head is the word being written this edge when it lands at the new read slot.
        head_d = '0;
        if (count_d != '0)
            head_d = (wr_en && (rd_ptr_d == wr_ptr_q)) ? push_data_i : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/instr_prefetch.sv
// Byte-serial instruction fetch: assembles big-endian words from a byte memory
// and queues them with their PC; redirects flush the queue and restart fetch.
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic              clk,
    input  logic              rst,
    instr_prefetch_if.master  bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = INSTR_W + AW;
    localparam int SW = INSTR_W - BYTE_W;

    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [1:0]    pend_idx_q, pend_idx_d;
    logic          rd_pend_q, rd_pend_d;
    logic [SW-1:0] shreg_q, shreg_d;

    logic          word_done;
    logic          push;
    logic          pop;
    logic          valid;
    logic          space_ok;
    logic          issue;
    logic [AW-1:0] redirect_base;
    logic [EW-1:0] push_data;
    logic [EW-1:0] head;
    logic [CW-1:0] count;

    assign redirect_base = bus.redirect_pc & ~AW'(INSTR_BYTES - 1);
    assign word_done     = rd_pend_q && (pend_idx_q == 2'd3);
    assign push          = word_done && !bus.redirect_valid;
    assign valid         = (count != '0);
    assign pop           = valid && bus.instr_ready;

    // A word completing at this edge already owns a slot, so it counts against the
    // space check; otherwise a new word could start with no room left for it.
    assign space_ok = (int'(count) + int'(word_done)) < DEPTH;
    assign issue    = !rst && !bus.redirect_valid && ((byte_idx_q != 2'd0) || space_ok);

    // The in-flight word's PC is one word behind fetch_pc, which advanced on byte 3.
    assign push_data = {shreg_q, bus.mem_rdata, fetch_pc_q - AW'(INSTR_BYTES)};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        byte_idx_d = byte_idx_q;
        pend_idx_d = pend_idx_q;
        rd_pend_d  = issue;
        shreg_d    = shreg_q;
        if (rd_pend_q) shreg_d = {shreg_q[SW-BYTE_W-1:0], bus.mem_rdata};
        if (issue) begin
            pend_idx_d = byte_idx_q;
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) fetch_pc_d = fetch_pc_q + AW'(INSTR_BYTES);
        end
        if (bus.redirect_valid) begin
            fetch_pc_d = redirect_base;
            byte_idx_d = '0;
            rd_pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= '0;
            byte_idx_q <= '0;
            pend_idx_q <= '0;
            rd_pend_q  <= 1'b0;
            shreg_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            byte_idx_q <= byte_idx_d;
            pend_idx_q <= pend_idx_d;
            rd_pend_q  <= rd_pend_d;
            shreg_q    <= shreg_d;
        end
    end

    instr_fifo #(
        .DEPTH (DEPTH),
        .DW    (EW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (bus.redirect_valid),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    assign bus.mem_rd      = issue;
    assign bus.mem_addr    = fetch_pc_q + AW'(byte_idx_q);
    assign bus.instr_valid = valid;
    assign bus.instr       = head[EW-1:AW];
    assign bus.instr_pc    = head[AW-1:0];
    assign bus.fifo_count  = count;

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: directed timing sequences, a redirect vector table and
// a randomized run scored against an in-order instruction-stream model.
module tb_instr_prefetch;
    import instr_prefetch_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_prefetch_if #(.AW(AW), .DEPTH(DEPTH)) bus ();
    instr_prefetch #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] imem [256];
    int total = 0;
    int bad   = 0;

    // Byte memory: data one cycle after the read strobe, garbage otherwise.
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= imem[bus.mem_addr];
        else            bus.mem_rdata <= 8'($urandom);
    end

    always @(negedge clk) begin
        if (!rst && bus.instr_valid && bus.instr_ready)
            $display("txn pop pc=%02h instr=%08h", bus.instr_pc, bus.instr);
        if (!rst && bus.redirect_valid)
            $display("txn redirect target=%02h", bus.redirect_pc);
    end

    typedef struct {
        logic [7:0] target;
        logic [7:0] base;
        logic [7:0] next_pc;
    } redir_vec_t;

    redir_vec_t vecs [6];

    function automatic logic [31:0] word_at(input logic [7:0] pc);
        return {imem[pc], imem[8'(pc + 8'd1)], imem[8'(pc + 8'd2)], imem[8'(pc + 8'd3)]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_zero(input string name);
        chk(name, {bus.mem_rd, bus.mem_addr, bus.instr_valid, bus.instr, bus.instr_pc, bus.fifo_count}, '0);
    endtask

    task automatic chk_head(input string name, input logic [7:0] pc);
        chk(name, {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, pc, word_at(pc)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the caller in cycle c0 (just after rst falls, inputs may be driven).
    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        step();
        chk_zero("rst_outputs");
        step();
        chk_zero("rst_hold");
        rst = 1'b0;
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b1;
        for (int i = 0; i < 256; i++) imem[i] = 8'(i * 17);

        vecs[0] = '{8'h42, 8'h40, 8'h44};
        vecs[1] = '{8'hFC, 8'hFC, 8'h00};
        vecs[2] = '{8'h13, 8'h10, 8'h14};
        vecs[3] = '{8'h00, 8'h00, 8'h04};
        vecs[4] = '{8'hFF, 8'hFC, 8'h00};
        vecs[5] = '{8'h81, 8'h80, 8'h84};

        // Startup timing: reads 0..3 in c0..c3, first word visible in c5, second in c9.
        bus.instr_ready = 1'b1;
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            if (c <= 3) chk($sformatf("boot_rd_c%0d", c), {bus.mem_rd, bus.mem_addr}, {1'b1, 8'(c)});
            if (c == 4) chk("boot_c4_empty", bus.instr_valid, 1'b0);
            if (c == 5) chk("boot_c5_head", {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 8'h00, 32'h00112233});
            if (c == 8) chk("boot_c8_empty", bus.instr_valid, 1'b0);
            if (c == 9) chk("boot_c9_head", {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 8'h04, 32'h44556677});
            step();
        end

        // Backpressure: queue fills to DEPTH, fetch idles, then drains in order and resumes at 16.
        bus.instr_ready = 1'b0;
        do_reset();
        repeat (30) step();
        @(negedge clk);
        chk("bp_count_full", bus.fifo_count, 3'd4);
        chk("bp_rd_idle", bus.mem_rd, 1'b0);
        step();
        bus.instr_ready = 1'b1;
        begin
            logic       seen;
            logic [7:0] first_addr;
            seen = 1'b0;
            first_addr = '0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk_head($sformatf("bp_pop%0d", k), 8'(4 * k));
                if (k == 0) chk("bp_no_rd_when_full", bus.mem_rd, 1'b0);
                if (bus.mem_rd && !seen) begin
                    seen = 1'b1;
                    first_addr = bus.mem_addr;
                end
                step();
            end
            chk("bp_resume_addr", {seen, first_addr}, {1'b1, 8'd16});
        end

        // Redirect to 0x42 while byte 2 of word 4 is in flight (c7).
        bus.instr_ready = 1'b0;
        do_reset();
        repeat (7) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 8'h42;
        @(negedge clk);
        chk("rif_pre_count", bus.fifo_count, 3'd1);
        chk("rif_no_rd", bus.mem_rd, 1'b0);
        step();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) chk("rif_flushed", bus.fifo_count, 3'd0);
            if (i < 4) chk($sformatf("rif_rd%0d", i), {bus.mem_rd, bus.mem_addr}, {1'b1, 8'(8'h40 + i)});
            if (i < 5) chk($sformatf("rif_empty%0d", i), bus.instr_valid, 1'b0);
            if (i == 5) chk_head("rif_target", 8'h40);
            step();
        end

        // Redirect vector table: alignment, read sequence incl. wrap, two delivered PCs.
        bus.instr_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc = vecs[v].target;
            @(negedge clk);
            chk($sformatf("tab%0d_redir_rd", v), bus.mem_rd, 1'b0);
            step();
            bus.redirect_valid = 1'b0;
            for (int i = 1; i <= 10; i++) begin
                @(negedge clk);
                if (i <= 8)
                    chk($sformatf("tab%0d_rd%0d", v, i), {bus.mem_rd, bus.mem_addr},
                        {1'b1, 8'(vecs[v].base + 8'(i - 1))});
                if (i == 5) chk($sformatf("tab%0d_empty", v), bus.instr_valid, 1'b0);
                if (i == 6) chk_head($sformatf("tab%0d_first", v), vecs[v].base);
                if (i == 10) chk_head($sformatf("tab%0d_second", v), vecs[v].next_pc);
                step();
            end
        end

        // Redirect, pop and push in one cycle (c8): queue ends empty, target arrives at r+6.
        bus.instr_ready = 1'b0;
        do_reset();
        repeat (8) step();
        bus.instr_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 8'h20;
        @(negedge clk);
        chk("rpp_head_valid", bus.instr_valid, 1'b1);
        step();
        bus.redirect_valid = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            if (j == 1) chk("rpp_count_zero", bus.fifo_count, 3'd0);
            if (j < 6) chk($sformatf("rpp_no_stale%0d", j), bus.instr_valid, 1'b0);
            if (j == 6) chk_head("rpp_target", 8'h20);
            step();
        end

        // Asynchronous reset in the middle of a word.
        bus.instr_ready = 1'b1;
        do_reset();
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk_zero("arst_immediate");
        do_reset();
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c <= 3) chk($sformatf("arst_rd_c%0d", c), {bus.mem_rd, bus.mem_addr}, {1'b1, 8'(c)});
            if (c == 5) chk_head("arst_first", 8'h00);
            step();
        end

        // Randomized run against an in-order stream model.
        for (int i = 0; i < 256; i++) imem[i] = 8'($urandom);
        bus.instr_ready = 1'b1;
        do_reset();
        begin
            logic [7:0]   exp_pc;
            logic [7:0]   exp_rd;
            int           hs;
            fetch_entry_t e;
            exp_pc = '0;
            exp_rd = '0;
            hs = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                bus.instr_ready    = ($urandom_range(0, 9) < 7);
                bus.redirect_valid = ($urandom_range(0, 99) < 4);
                bus.redirect_pc    = 8'($urandom);
                @(negedge clk);
                chk("rnd_valid_vs_count", bus.instr_valid, (bus.fifo_count != '0));
                chk("rnd_count_bound", (bus.fifo_count <= 3'(DEPTH)), 1'b1);
                if (!bus.instr_valid) chk("rnd_empty_zero", {bus.instr, bus.instr_pc}, '0);
                if (bus.instr_valid && bus.instr_ready) begin
                    e.instr = word_at(exp_pc);
                    e.pc    = exp_pc;
                    chk("rnd_pop", {bus.instr, bus.instr_pc}, e);
                    exp_pc = exp_pc + 8'd4;
                    hs++;
                end
                if (bus.redirect_valid) begin
                    chk("rnd_redir_no_rd", bus.mem_rd, 1'b0);
                    exp_pc = {bus.redirect_pc[7:2], 2'b00};
                    exp_rd = exp_pc;
                end else if (bus.mem_rd) begin
                    chk("rnd_rd_addr", bus.mem_addr, exp_rd);
                    exp_rd = exp_rd + 8'd1;
                end
                step();
            end
            bus.redirect_valid = 1'b0;
            chk("rnd_progress", (hs >= 200), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
